counter_updown_mod: RTL

Parametrised synchronous up/down counter with preset, programmable modulus, wrap or stop-at-terminal mode, and cascade carry in/out. It is the general-purpose successor to the plain preset-able up counter. It serves as the timebase, divider and event counter in lab datapaths. Instances chain through `carry_in`/`carry_out` into wider or multi-digit counters, for example BCD with `mod_max`=9.

---
 rtl/counter_updown_mod_pkg.sv | 14 +
 rtl/counter_updown_mod_tc_detect.sv | 36 +++
 rtl/counter_updown_mod.sv | 98 +++++++++
 3 files changed

// File: rtl/counter_updown_mod_pkg.sv
// Shared definitions for the counter family.
// Holds the mode encodings for up_dn and stop_mode so every counter block
// that drives or decodes these controls agrees on their polarity.
package counter_updown_mod_pkg;

  // up_dn encodings
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;

  // stop_mode encodings
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_STOP = 1'b1;

endpackage

// File: rtl/counter_updown_mod_tc_detect.sv
// counter_tc_detect: combinational terminal-count and next-value logic.
// Ports:
//   counter_out - current count
//   up_dn       - 1 = up, 0 = down
//   mod_max     - terminal value for up count (cycle length mod_max+1)
//   terminal    - current count is at (or, counting up, beyond) the terminal value
//   next_val    - value the counter moves to on a step in wrap mode
module counter_tc_detect
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] counter_out,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] mod_max,
  output logic             terminal,
  output logic [WIDTH-1:0] next_val
);

  always_comb begin
    terminal = 1'b0;
    next_val = counter_out;
    if (up_dn == CNT_UP) begin
      // >= so an out-of-range value (after load or a mod_max change)
      // is treated as terminal and recovers by wrapping to 0.
      terminal = (counter_out >= mod_max);
      next_val = terminal ? '0 : counter_out + WIDTH'(1);
    end else begin
      // Down counting only terminates at 0; out-of-range values simply
      // decrement back into range.
      terminal = (counter_out == '0);
      next_val = terminal ? mod_max : counter_out - WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: up/down counter with preset, programmable modulus,
// wrap or stop-at-terminal mode and cascade carry.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   clear         - sync clear to RST_VAL (highest sync priority)
//   load          - sync preset from data_preset
//   count_en      - count enable
//   carry_in      - cascade enable from previous stage (tie 1 on first stage)
//   up_dn         - 1 = up, 0 = down
//   stop_mode     - 0 = wrap at terminal, 1 = hold at terminal
//   mod_max       - terminal value for up count
//   counter_out   - registered count
//   carry_out     - combinational terminal strobe, feeds next stage carry_in
//   wrap_pulse    - registered, high the cycle after a wrap
//   done          - registered sticky flag, set by a stop-mode hold
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_preset,
  input  logic             count_en,
  input  logic             carry_in,
  input  logic             up_dn,
  input  logic             stop_mode,
  input  logic [WIDTH-1:0] mod_max,
  output logic [WIDTH-1:0] counter_out,
  output logic             carry_out,
  output logic             wrap_pulse,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             step;
  logic             terminal;
  logic [WIDTH-1:0] next_val;
  logic             term_step;  // a step taken at terminal, not overridden

  counter_tc_detect #(.WIDTH(WIDTH)) u_tc (
    .counter_out (cnt_q),
    .up_dn       (up_dn),
    .mod_max     (mod_max),
    .terminal    (terminal),
    .next_val    (next_val)
  );

  assign step      = count_en & carry_in;
  assign term_step = ~clear & ~load & step & terminal;

  // Asserted in both modes; downstream stages gate on done if they care.
  assign carry_out = term_step;

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    done_d = done_q;
    if (clear) begin
      cnt_d  = RST_V;
      done_d = 1'b0;
    end else if (load) begin
      cnt_d  = data_preset;
      done_d = 1'b0;
    end else if (step) begin
      if (terminal && stop_mode == CNT_STOP) begin
        done_d = 1'b1;  // hold count
      end else begin
        cnt_d  = next_val;
        wrap_d = terminal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= RST_V;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      done_q <= done_d;
    end
  end

  assign counter_out = cnt_q;
  assign wrap_pulse  = wrap_q;
  assign done        = done_q;

endmodule
